// File: rtl/huff_merge_ctrl_pkg.sv
// Shared constants and state encoding for the Huffman merge controller.
package huff_pkg;

  localparam int CNT_W = 8;
  localparam int TAG_W = 3;
  localparam int NSYM  = 6;

  // Tag carried by an inactive (zero-count) entry.
  localparam int TAG_NONE = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT,
    MERGE
  } state_t;

endpackage

// File: rtl/huff_merge_ctrl.sv
// Huffman merge scheduler: drives an external 6-entry descending sorter,
// merges the two smallest live entries each round and emits merge records.
module huff_merge_ctrl
  import huff_pkg::*;
#(
  parameter int CNT_W = huff_pkg::CNT_W,
  parameter int TAG_W = huff_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt1,
  input  logic [CNT_W-1:0] cnt2,
  input  logic [CNT_W-1:0] cnt3,
  input  logic [CNT_W-1:0] cnt4,
  input  logic [CNT_W-1:0] cnt5,
  input  logic [CNT_W-1:0] cnt6,
  output logic             busy,
  output logic [CNT_W-1:0] sort_in1,
  output logic [CNT_W-1:0] sort_in2,
  output logic [CNT_W-1:0] sort_in3,
  output logic [CNT_W-1:0] sort_in4,
  output logic [CNT_W-1:0] sort_in5,
  output logic [CNT_W-1:0] sort_in6,
  output logic [TAG_W-1:0] sort_win1,
  output logic [TAG_W-1:0] sort_win2,
  output logic [TAG_W-1:0] sort_win3,
  output logic [TAG_W-1:0] sort_win4,
  output logic [TAG_W-1:0] sort_win5,
  output logic [TAG_W-1:0] sort_win6,
  input  logic [CNT_W-1:0] sort_out1,
  input  logic [CNT_W-1:0] sort_out2,
  input  logic [CNT_W-1:0] sort_out3,
  input  logic [CNT_W-1:0] sort_out4,
  input  logic [CNT_W-1:0] sort_out5,
  input  logic [CNT_W-1:0] sort_out6,
  input  logic [TAG_W-1:0] sort_wout1,
  input  logic [TAG_W-1:0] sort_wout2,
  input  logic [TAG_W-1:0] sort_wout3,
  input  logic [TAG_W-1:0] sort_wout4,
  input  logic [TAG_W-1:0] sort_wout5,
  input  logic [TAG_W-1:0] sort_wout6,
  output logic             merge_vld,
  output logic [2:0]       merge_step,
  output logic [TAG_W-1:0] merge_hi_tag,
  output logic [TAG_W-1:0] merge_lo_tag,
  output logic [CNT_W-1:0] merge_sum,
  output logic             ovf,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ent_c_q [NSYM];
  logic [CNT_W-1:0] ent_c_d [NSYM];
  logic [TAG_W-1:0] ent_t_q [NSYM];
  logic [TAG_W-1:0] ent_t_d [NSYM];
  logic [2:0]       n_q, n_d;
  logic [2:0]       round_q, round_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             mvld_q, mvld_d;
  logic [2:0]       mstep_q, mstep_d;
  logic [TAG_W-1:0] mhi_q, mhi_d;
  logic [TAG_W-1:0] mlo_q, mlo_d;
  logic [CNT_W-1:0] msum_q, msum_d;

  logic [CNT_W-1:0] cnt_in [NSYM];
  logic [CNT_W-1:0] so_c   [NSYM];
  logic [TAG_W-1:0] so_t   [NSYM];
  logic [2:0]       live_cnt;
  logic [2:0]       idx_hi, idx_lo;
  logic [CNT_W:0]   sum_full;
  logic [CNT_W-1:0] sum_sat;

  assign cnt_in = '{cnt1, cnt2, cnt3, cnt4, cnt5, cnt6};
  assign so_c   = '{sort_out1, sort_out2, sort_out3, sort_out4, sort_out5, sort_out6};
  assign so_t   = '{sort_wout1, sort_wout2, sort_wout3, sort_wout4, sort_wout5, sort_wout6};

  // Number of nonzero symbol counts presented with start.
  always_comb begin
    live_cnt = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (cnt_in[i] != '0) live_cnt = live_cnt + 3'd1;
    end
  end

  // Two smallest live entries sit at sorted positions n-1 and n (0-based n-2, n-1);
  // clamped so indices stay in range when no merge is in progress.
  always_comb begin
    if (n_q >= 3'd2) begin
      idx_hi = n_q - 3'd2;
      idx_lo = n_q - 3'd1;
    end else begin
      idx_hi = 3'd0;
      idx_lo = 3'd1;
    end
    sum_full = {1'b0, so_c[idx_hi]} + {1'b0, so_c[idx_lo]};
    sum_sat  = sum_full[CNT_W] ? '1 : sum_full[CNT_W-1:0];
  end

  // Next-state and next-register logic for the round sequencer.
  always_comb begin
    state_d = state_q;
    ent_c_d = ent_c_q;
    ent_t_d = ent_t_q;
    n_d     = n_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    mvld_d  = 1'b0;
    mstep_d = mstep_q;
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    msum_d  = msum_q;

    case (state_q)
      IDLE: begin
        // busy is still high in the done cycle, so start is ignored there.
        busy_d = 1'b0;
        if (start && !busy_q) begin
          for (int unsigned i = 0; i < NSYM; i++) begin
            ent_c_d[i] = cnt_in[i];
            ent_t_d[i] = (cnt_in[i] != '0) ? TAG_W'(i + 1) : TAG_W'(TAG_NONE);
          end
          n_d     = live_cnt;
          round_d = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          if (live_cnt >= 3'd2) state_d = SETTLE;
          else                  done_d  = 1'b1;
        end
      end
      SETTLE: state_d = WAIT;
      WAIT:   state_d = MERGE;
      MERGE: begin
        for (int unsigned i = 0; i < NSYM; i++) begin
          if (3'(i) < idx_hi) begin
            ent_c_d[i] = so_c[i];
            ent_t_d[i] = so_t[i];
          end else if (3'(i) == idx_hi) begin
            ent_c_d[i] = sum_sat;
            ent_t_d[i] = so_t[idx_hi];
          end else begin
            ent_c_d[i] = '0;
            ent_t_d[i] = TAG_W'(TAG_NONE);
          end
        end
        mvld_d  = 1'b1;
        mstep_d = round_q;
        mhi_d   = so_t[idx_hi];
        mlo_d   = so_t[idx_lo];
        msum_d  = sum_sat;
        ovf_d   = ovf_q | sum_full[CNT_W];
        n_d     = n_q - 3'd1;
        round_d = round_q + 3'd1;
        if (n_q == 3'd2) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ent_c_q <= '{default: '0};
      ent_t_q <= '{default: '0};
      n_q     <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mvld_q  <= 1'b0;
      mstep_q <= '0;
      mhi_q   <= '0;
      mlo_q   <= '0;
      msum_q  <= '0;
    end else begin
      state_q <= state_d;
      ent_c_q <= ent_c_d;
      ent_t_q <= ent_t_d;
      n_q     <= n_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      mvld_q  <= mvld_d;
      mstep_q <= mstep_d;
      mhi_q   <= mhi_d;
      mlo_q   <= mlo_d;
      msum_q  <= msum_d;
    end
  end

  assign sort_in1  = ent_c_q[0];
  assign sort_in2  = ent_c_q[1];
  assign sort_in3  = ent_c_q[2];
  assign sort_in4  = ent_c_q[3];
  assign sort_in5  = ent_c_q[4];
  assign sort_in6  = ent_c_q[5];
  assign sort_win1 = ent_t_q[0];
  assign sort_win2 = ent_t_q[1];
  assign sort_win3 = ent_t_q[2];
  assign sort_win4 = ent_t_q[3];
  assign sort_win5 = ent_t_q[4];
  assign sort_win6 = ent_t_q[5];

  assign busy         = busy_q;
  assign done         = done_q;
  assign ovf          = ovf_q;
  assign merge_vld    = mvld_q;
  assign merge_step   = mstep_q;
  assign merge_hi_tag = mhi_q;
  assign merge_lo_tag = mlo_q;
  assign merge_sum    = msum_q;

endmodule
